fetch_unit: RTL

- Instruction-fetch stage of the RISC-V core. Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with a valid-only response.
- Presents {instr, pc, pc+4} in an IF/ID output register to decode (immediate generation, control).
- Accepts a one-cycle redirect from execute (taken BEQ, J) carrying the already-computed pc+imm target.

---
 rtl/fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction-fetch stage owning the PC, issuing one word fetch at a time,
// and presenting {instr, pc, pc+4} to decode through an IF/ID register backed by a 1-entry skid.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_next;
    logic [31:0] pc, req_pc, skid_instr, skid_pc;
    logic drop, skid_valid, accept, land, out_free;

    assign accept   = imem_req_valid && imem_req_ready;
    assign land     = state == WAIT && imem_rsp_valid && !drop && !redirect_valid;
    assign out_free = !if_id_valid || id_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state == IDLE ? REQ :
                     state == REQ  ? (accept ? WAIT : REQ) :
                                     (imem_rsp_valid ? REQ : WAIT);
    end

    // A full skid holds off new requests so a landing response always has somewhere to go.
    always_comb begin
        imem_req_valid = state == REQ && !skid_valid;
        imem_req_addr  = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            drop        <= 1'b0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= RESET_PC;
            if_id_pc4   <= RESET_PC + 32'd4;
        end else begin
            if (redirect_valid) pc <= {redirect_target[31:2], 2'b00};
            else if (accept) pc <= pc + 32'd4;
            if (accept) req_pc <= pc;
            // An in-flight request overtaken by a redirect must have its response swallowed.
            if (redirect_valid && (accept || (state == WAIT && !imem_rsp_valid))) drop <= 1'b1;
            else if (state == WAIT && imem_rsp_valid) drop <= 1'b0;
            if (redirect_valid) begin
                if_id_valid <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (out_free) begin
                if (skid_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= skid_instr;
                    if_id_pc    <= skid_pc;
                    if_id_pc4   <= skid_pc + 32'd4;
                    skid_valid  <= 1'b0;
                end else if (land) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= imem_rsp_data;
                    if_id_pc    <= req_pc;
                    if_id_pc4   <= req_pc + 32'd4;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end else if (land) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rsp_data;
                skid_pc    <= req_pc;
            end
        end
    end
endmodule
